// File: rtl/ans_table_ctrl_pkg.sv
// ans_table_ctrl_pkg: shared defaults and controller state encoding for the ANS table controller
package ans_table_ctrl_pkg;
    localparam int SYM_WIDTH       = 4;
    localparam int SYM_COUNT       = 16;
    localparam int CNT_WIDTH       = 8;
    localparam int CUM_WIDTH       = CNT_WIDTH + SYM_WIDTH;
    localparam int NIBBLES_PER_CNT = CNT_WIDTH / 4;
    typedef enum logic [2:0] {IDLE, LOAD, PREFIX, RUN, ERR} state_e;
endpackage

// File: rtl/ans_prefix_sum.sv
// ans_prefix_sum: one-adder sequential inclusive prefix sum, one symbol per cycle after start
module ans_prefix_sum #(
    parameter int SYM_WIDTH = ans_table_ctrl_pkg::SYM_WIDTH,
    parameter int SYM_COUNT = ans_table_ctrl_pkg::SYM_COUNT,
    parameter int CNT_WIDTH = ans_table_ctrl_pkg::CNT_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start_i,
    input  logic [CNT_WIDTH*SYM_COUNT-1:0]             counts_i,
    output logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cum_o,
    output logic                                       done_o,
    output logic [CNT_WIDTH+SYM_WIDTH-1:0]             total_o
);
    localparam int CW = CNT_WIDTH + SYM_WIDTH;
    logic                    busy_q;
    logic [SYM_WIDTH-1:0]    idx_q;
    logic [CW-1:0]           acc_q;
    logic [CW*SYM_COUNT-1:0] cum_q;
    logic [CW-1:0]           sum;
    assign sum     = acc_q + CW'(counts_i[idx_q*CNT_WIDTH +: CNT_WIDTH]);
    assign done_o  = busy_q && idx_q == SYM_WIDTH'(SYM_COUNT - 1);
    assign total_o = sum;
    assign cum_o   = cum_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            idx_q  <= '0;
            acc_q  <= '0;
            cum_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            idx_q  <= '0;
            acc_q  <= '0;
        end else if (busy_q) begin
            cum_q[idx_q*CW +: CW] <= sum;
            acc_q                 <= sum;
            idx_q                 <= idx_q + 1'b1;
            busy_q                <= !done_o;
        end
    end
endmodule

// File: rtl/ans_table_ctrl.sv
// ans_table_ctrl: loads the ANS frequency table, builds its prefix sums and sequences decoder frames
module ans_table_ctrl #(
    parameter int SYM_WIDTH   = ans_table_ctrl_pkg::SYM_WIDTH,
    parameter int SYM_COUNT   = ans_table_ctrl_pkg::SYM_COUNT,
    parameter int CNT_WIDTH   = ans_table_ctrl_pkg::CNT_WIDTH,
    parameter int FRAME_WIDTH = 16
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       cfg_start_i,
    input  logic                                       run_start_i,
    input  logic [FRAME_WIDTH-1:0]                     frame_len_i,
    input  logic [3:0]                                 cfg_data_i,
    input  logic                                       cfg_vld_i,
    output logic                                       cfg_rdy_o,
    output logic [CNT_WIDTH*SYM_COUNT-1:0]             counts_unpacked_o,
    output logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked_o,
    output logic                                       table_vld_o,
    output logic                                       dec_rst_n_o,
    output logic                                       dec_ena_o,
    input  logic                                       dec_out_vld_i,
    input  logic                                       dec_out_rdy_i,
    output logic                                       frame_done_o,
    output logic                                       err_o
);
    import ans_table_ctrl_pkg::*;
    localparam int CW = CNT_WIDTH + SYM_WIDTH;
    localparam int NT = SYM_COUNT * CNT_WIDTH / 4;
    localparam int XW = $clog2(NT);
    state_e                         state_q, state_d;
    logic                           cfg_rdy_q, cfg_rdy_d, table_vld_q, table_vld_d;
    logic                           dec_rst_n_q, dec_rst_n_d, dec_ena_q, dec_ena_d;
    logic                           frame_done_q, frame_done_d, err_q, err_d;
    logic [CNT_WIDTH*SYM_COUNT-1:0] counts_q, counts_d;
    logic [XW-1:0]                  xfer_q, xfer_d;
    logic [FRAME_WIDTH-1:0]         flen_q, flen_d, fcnt_q, fcnt_d;
    logic                           hs, frame_end, p_start, p_done;
    logic [CW-1:0]                  p_total;
    assign hs        = dec_out_vld_i && dec_out_rdy_i;
    assign frame_end = fcnt_q == flen_q || (hs && fcnt_q + 1'b1 == flen_q);
    assign p_start   = state_q == LOAD && cfg_vld_i && cfg_rdy_q && xfer_q == XW'(NT - 1);
    ans_prefix_sum #(.SYM_WIDTH(SYM_WIDTH), .SYM_COUNT(SYM_COUNT), .CNT_WIDTH(CNT_WIDTH)) u_prefix (
        .clk     (clk),
        .rst     (rst),
        .start_i (p_start),
        .counts_i(counts_q),
        .cum_o   (cumulative_unpacked_o),
        .done_o  (p_done),
        .total_o (p_total)
    );
    always_comb begin
        state_d      = state_q;
        cfg_rdy_d    = cfg_rdy_q;
        table_vld_d  = table_vld_q;
        dec_rst_n_d  = dec_rst_n_q;
        dec_ena_d    = dec_ena_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
        counts_d     = counts_q;
        xfer_d       = xfer_q;
        flen_d       = flen_q;
        fcnt_d       = fcnt_q;
        case (state_q)
            IDLE, ERR: begin
                if (cfg_start_i) begin
                    state_d     = LOAD;
                    cfg_rdy_d   = 1'b1;
                    table_vld_d = 1'b0;
                    err_d       = 1'b0;
                    xfer_d      = '0;
                    flen_d      = frame_len_i;
                end else if (state_q == IDLE && run_start_i && table_vld_q) begin
                    state_d     = RUN;
                    flen_d      = frame_len_i;
                    fcnt_d      = '0;
                    dec_rst_n_d = 1'b1;
                    dec_ena_d   = 1'b1;
                end
            end
            LOAD: begin
                if (cfg_vld_i && cfg_rdy_q) begin
                    counts_d[{xfer_q, 2'b00} +: 4] = cfg_data_i;
                    xfer_d = xfer_q + 1'b1;
                    if (p_start) begin
                        state_d   = PREFIX;
                        cfg_rdy_d = 1'b0;
                    end
                end
            end
            PREFIX: begin
                if (p_done) begin
                    state_d     = p_total == '0 ? ERR : RUN;
                    err_d       = p_total == '0;
                    table_vld_d = p_total != '0;
                    dec_rst_n_d = p_total != '0;
                    dec_ena_d   = p_total != '0;
                    fcnt_d      = '0;
                end
            end
            RUN: begin
                fcnt_d = hs ? fcnt_q + 1'b1 : fcnt_q;
                if (frame_end) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    dec_rst_n_d  = 1'b0;
                    dec_ena_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cfg_rdy_q    <= 1'b0;
            table_vld_q  <= 1'b0;
            dec_rst_n_q  <= 1'b0;
            dec_ena_q    <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            counts_q     <= '0;
            xfer_q       <= '0;
            flen_q       <= '0;
            fcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            cfg_rdy_q    <= cfg_rdy_d;
            table_vld_q  <= table_vld_d;
            dec_rst_n_q  <= dec_rst_n_d;
            dec_ena_q    <= dec_ena_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            counts_q     <= counts_d;
            xfer_q       <= xfer_d;
            flen_q       <= flen_d;
            fcnt_q       <= fcnt_d;
        end
    end
    assign cfg_rdy_o         = cfg_rdy_q;
    assign table_vld_o       = table_vld_q;
    assign dec_rst_n_o       = dec_rst_n_q;
    assign dec_ena_o         = dec_ena_q;
    assign frame_done_o      = frame_done_q;
    assign err_o             = err_q;
    assign counts_unpacked_o = counts_q;
endmodule

// File: tb/tb_ans_table_ctrl.sv
// tb_ans_table_ctrl: randomized bench comparing the controller against a phase-level reference model
module tb_ans_table_ctrl;
    localparam int SW = 4, SC = 16, CWD = 8, FW = 16, UW = CWD + SW, NPC = CWD / 4, NT = SC * NPC;
    localparam int M_IDLE = 0, M_LOAD = 1, M_PREFIX = 2, M_RUN = 3, M_ERR = 4;
    logic clk = 0, rst = 1;
    logic cfg_start = 0, run_start = 0, cfg_vld = 0, dec_out_vld = 0, dec_out_rdy = 0;
    logic [FW-1:0] frame_len = '0;
    logic [3:0] cfg_data = '0;
    logic cfg_rdy_o, table_vld_o, dec_rst_n_o, dec_ena_o, frame_done_o, err_o;
    logic [CWD*SC-1:0] counts_unpacked_o;
    logic [UW*SC-1:0] cumulative_unpacked_o;
    int checks = 0, errors = 0;
    bit started = 0;
    int tbl[SC];
    int m_ph, m_k, m_pc, m_fc, m_flen, m_cnt[SC], m_cum[SC];
    bit m_tvld, m_done;

    always #5 clk = ~clk;

    ans_table_ctrl dut (
        .clk(clk), .rst(rst), .cfg_start_i(cfg_start), .run_start_i(run_start), .frame_len_i(frame_len),
        .cfg_data_i(cfg_data), .cfg_vld_i(cfg_vld), .cfg_rdy_o(cfg_rdy_o),
        .counts_unpacked_o(counts_unpacked_o), .cumulative_unpacked_o(cumulative_unpacked_o),
        .table_vld_o(table_vld_o), .dec_rst_n_o(dec_rst_n_o), .dec_ena_o(dec_ena_o),
        .dec_out_vld_i(dec_out_vld), .dec_out_rdy_i(dec_out_rdy), .frame_done_o(frame_done_o), .err_o(err_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: phases and whole-table arithmetic, updated on each rising edge
    initial forever begin
        int sh, acc;
        @(posedge clk);
        if (rst) begin
            m_ph = M_IDLE; m_tvld = 0; m_done = 0; m_k = 0; m_pc = 0; m_fc = 0; m_flen = 0;
            for (int i = 0; i < SC; i++) begin m_cnt[i] = 0; m_cum[i] = 0; end
        end else begin
            m_done = 0;
            if ((m_ph == M_IDLE || m_ph == M_ERR) && cfg_start) begin
                m_ph = M_LOAD; m_tvld = 0; m_k = 0; m_flen = int'(frame_len);
            end else if (m_ph == M_IDLE && run_start && m_tvld) begin
                m_ph = M_RUN; m_fc = 0; m_flen = int'(frame_len);
            end else if (m_ph == M_LOAD && cfg_vld) begin
                sh = 4 * (m_k % NPC);
                m_cnt[m_k / NPC] = (m_cnt[m_k / NPC] & ~(15 << sh)) | (int'(cfg_data) << sh);
                m_k++;
                if (m_k == NT) begin m_ph = M_PREFIX; m_pc = 0; end
            end else if (m_ph == M_PREFIX) begin
                m_pc++;
                if (m_pc == SC) begin
                    acc = 0;
                    for (int i = 0; i < SC; i++) begin acc += m_cnt[i]; m_cum[i] = acc; end
                    if (acc == 0) m_ph = M_ERR;
                    else begin m_tvld = 1; m_fc = 0; m_ph = M_RUN; end
                end
            end else if (m_ph == M_RUN) begin
                if (dec_out_vld && dec_out_rdy) m_fc++;
                if (m_flen == 0 || m_fc == m_flen) begin m_done = 1; m_ph = M_IDLE; end
            end
        end
    end

    initial forever begin
        logic [CWD*SC-1:0] ec;
        logic [UW*SC-1:0] eu;
        @(negedge clk);
        if (started) begin
            for (int i = 0; i < SC; i++) begin
                ec[i*CWD +: CWD] = m_cnt[i][CWD-1:0];
                eu[i*UW +: UW] = m_cum[i][UW-1:0];
            end
            chkv("counts", 192'(counts_unpacked_o), 192'(ec));
            if (m_ph != M_PREFIX) chkv("cumulative", cumulative_unpacked_o, eu);
            chk("cfg_rdy", int'(cfg_rdy_o), int'(m_ph == M_LOAD));
            chk("table_vld", int'(table_vld_o), int'(m_tvld));
            chk("dec_rst_n", int'(dec_rst_n_o), int'(m_ph == M_RUN));
            chk("dec_ena", int'(dec_ena_o), int'(m_ph == M_RUN));
            chk("frame_done", int'(frame_done_o), int'(m_done));
            chk("err", int'(err_o), int'(m_ph == M_ERR));
        end
    end

    task automatic pulse_start(input bit c, input bit r, input int len);
        @(negedge clk);
        cfg_start = c; run_start = r; frame_len = FW'(len);
        @(negedge clk);
        cfg_start = 0; run_start = 0;
    endtask

    task automatic send_table(input int maxn);
        int k = 0, guard = 0;
        bit v;
        while (k < maxn && guard < 2000) begin
            v = $urandom_range(0, 3) != 0;
            cfg_vld = v;
            cfg_data = 4'(tbl[k / NPC] >> (4 * (k % NPC)));
            if (v && cfg_rdy_o) k++;
            @(negedge clk);
            guard++;
        end
        cfg_vld = 0;
        chk("load_progress", k, maxn);
    endtask

    task automatic wait_table();
        for (int i = 0; i < 40 && !(table_vld_o || err_o); i++) @(negedge clk);
        chk("table_ready", int'(table_vld_o || err_o), 1);
    endtask

    task automatic load_full(input bit r, input int len);
        pulse_start(1, r, len);
        send_table(NT);
        chk("rdy_drop", int'(cfg_rdy_o), 0);
        wait_table();
    endtask

    task automatic drive_frame(input int mode, output int hs, output int cyc);
        bit v, r;
        hs = 0; cyc = 0;
        while (!frame_done_o && cyc < 500) begin
            cyc++;
            if (mode == 0) begin v = cyc % 2 == 1; r = v; end
            else if (mode == 1) begin v = $urandom_range(0, 1) == 1; r = $urandom_range(0, 1) == 1; end
            else begin v = 0; r = 0; end
            dec_out_vld = v; dec_out_rdy = r;
            if (v && r && dec_ena_o) hs++;
            @(negedge clk);
        end
        dec_out_vld = 0; dec_out_rdy = 0;
        chk("frame_seen", int'(frame_done_o), 1);
    endtask

    initial begin
        int hs, cyc, l;
        repeat (3) @(negedge clk);
        rst = 0; started = 1;
        chk("rst_cfg_rdy", int'(cfg_rdy_o), 0);
        chk("rst_dec_rst_n", int'(dec_rst_n_o), 0);
        chk("rst_table_vld", int'(table_vld_o), 0);
        chkv("rst_counts", 192'(counts_unpacked_o), '0);
        // all ones: cumulative[i] must be i+1
        foreach (tbl[i]) tbl[i] = 1;
        load_full(0, 4);
        for (int i = 0; i < SC; i++) chk($sformatf("ones_cum%0d", i), int'(cumulative_unpacked_o[i*UW +: UW]), i + 1);
        drive_frame(1, hs, cyc);
        chk("ones_hs", hs, 4);
        pulse_start(0, 1, 5);
        drive_frame(0, hs, cyc);
        chk("len5_hs", hs, 5);
        chk("len5_cycles", cyc, 9);
        pulse_start(0, 1, 3);
        drive_frame(1, hs, cyc);
        chk("replay_hs", hs, 3);
        pulse_start(0, 1, 0);
        drive_frame(2, hs, cyc);
        chk("len0_cycles", cyc, 1);
        // simultaneous cfg_start/run_start: load wins; all 255 must not overflow
        foreach (tbl[i]) tbl[i] = 255;
        pulse_start(1, 1, 2);
        chk("both_start_load", int'(cfg_rdy_o), 1);
        send_table(NT);
        wait_table();
        chk("max_cum15", int'(cumulative_unpacked_o[15*UW +: UW]), 4080);
        drive_frame(1, hs, cyc);
        chk("max_hs", hs, 2);
        foreach (tbl[i]) tbl[i] = $urandom_range(0, 255);
        tbl[2] = 'h3C;
        load_full(0, 6);
        chk("nibble_order", int'(counts_unpacked_o[2*CWD +: CWD]), 'h3C);
        drive_frame(1, hs, cyc);
        chk("rand_hs6", hs, 6);
        // zero table leads to ERR; run_start is ignored there
        foreach (tbl[i]) tbl[i] = 0;
        load_full(0, 5);
        chk("zero_err", int'(err_o), 1);
        chk("zero_tvld", int'(table_vld_o), 0);
        chk("zero_rst_n", int'(dec_rst_n_o), 0);
        pulse_start(0, 1, 3);
        chk("err_run_ignored", int'(dec_ena_o), 0);
        foreach (tbl[i]) tbl[i] = $urandom_range(1, 255);
        pulse_start(1, 0, 2);
        chk("err_cleared", int'(err_o), 0);
        chk("err_reload", int'(cfg_rdy_o), 1);
        send_table(NT);
        wait_table();
        drive_frame(1, hs, cyc);
        chk("reload_hs", hs, 2);
        // reset mid-load with cfg_vld held high
        pulse_start(1, 0, 3);
        send_table(10);
        rst = 1; cfg_vld = 1;
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("midrst_rdy", int'(cfg_rdy_o), 0);
        chkv("midrst_counts", 192'(counts_unpacked_o), '0);
        cfg_vld = 0;
        for (int t = 0; t < 4; t++) begin
            foreach (tbl[i]) tbl[i] = $urandom_range(0, 255);
            l = $urandom_range(0, 6);
            load_full(0, l);
            if (table_vld_o) begin
                drive_frame(1, hs, cyc);
                if (l > 0) chk("rand_hs", hs, l);
            end
        end
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ans_table_ctrl.md
Name: ans_table_ctrl

Overview:
- Configuration and sequencing controller for the ANS decoder datapath.
- Receives a symbol-frequency table as a 4-bit nibble stream and stores per-symbol counts.
- Builds the inclusive cumulative table with one sequential adder and drives both tables to the decoder in packed form.
- Holds the decoder in reset until the table is valid, then enables it for exactly frame_len output symbols and signals frame completion.

Parameters:
- SYM_WIDTH, 4, symbol width in bits; also the nibble width of the config stream.
- SYM_COUNT, 16, number of symbols (at most 2**SYM_WIDTH).
- CNT_WIDTH, 8, per-symbol count width; must be a multiple of 4.
- FRAME_WIDTH, 16, width of the frame symbol counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  single-cycle request to load a new table; honoured only in IDLE or ERR.
- run_start  in  1  single-cycle request to decode a new frame with the stored table; honoured only in IDLE with table_vld=1.
- frame_len  in  FRAME_WIDTH  symbols per frame; sampled on an honoured cfg_start or run_start.
- cfg_data  in  4  count nibble.
- cfg_vld  in  1  cfg_data valid.
- cfg_rdy  out  1  controller accepts a nibble.
- counts_unpacked  out  CNT_WIDTH*SYM_COUNT  packed counts; symbol i at bits [i*CNT_WIDTH +: CNT_WIDTH].
- cumulative_unpacked  out  (CNT_WIDTH+SYM_WIDTH)*SYM_COUNT  packed inclusive prefix sums; same packing scheme.
- table_vld  out  1  both tables are consistent and usable.
- dec_rst_n  out  1  active-low reset to the decoder.
- dec_ena  out  1  enable to the decoder.
- dec_out_vld  in  1  decoder output valid (monitored).
- dec_out_rdy  in  1  sink ready (monitored).
- frame_done  out  1  single-cycle pulse when the frame completes.
- err  out  1  loaded table has total count zero.

Behaviour:
- State machine: IDLE, LOAD, PREFIX, RUN, ERR.
- Reset values: state IDLE; cfg_rdy 0, table_vld 0, dec_rst_n 0, dec_ena 0, frame_done 0, err 0; all count, cumulative and frame counters 0.
- All outputs are registered.
- IDLE + cfg_start:
  - clear table_vld and err;
  - zero the nibble and symbol indices;
  - latch frame_len;
  - go to LOAD with cfg_rdy=1 on the next cycle.
- IDLE + run_start (table_vld=1): latch frame_len, clear frame counter, go to RUN.
- cfg_start and run_start in the same cycle: cfg_start wins.
- Start requests in any other state are ignored.
- LOAD:
  - A nibble transfers when cfg_vld && cfg_rdy (cfg_rdy held 1 for the whole state).
  - Nibble k of symbol i lands in counts[i][4k +: 4]; nibbles arrive low first, symbols arrive 0 first.
  - The state needs SYM_COUNT*CNT_WIDTH/4 transfers.
  - On the final transfer, cfg_rdy drops the following cycle and the state becomes PREFIX.
  - cfg_vld with cfg_rdy=0 is never consumed.
- PREFIX:
  - One symbol per cycle, SYM_COUNT cycles.
  - cumulative[0] = counts[0]; cumulative[i] = cumulative[i-1] + counts[i], zero-extended to CNT_WIDTH+SYM_WIDTH bits. Cannot overflow.
  - After the last symbol:
    - if cumulative[SYM_COUNT-1] == 0: go to ERR with err=1;
    - otherwise: table_vld=1, clear frame counter, go to RUN.
- RUN:
  - dec_rst_n=1 and dec_ena=1 from the first RUN cycle.
  - Each cycle with dec_out_vld && dec_out_rdy increments the frame counter.
  - When the count reaches the latched frame_len:
    - frame_done pulses for one cycle;
    - dec_ena and dec_rst_n go 0 in that same registered cycle;
    - state returns to IDLE.
  - frame_len==0: frame_done pulses on the first RUN cycle; no symbols are consumed.
- ERR: err held at 1, table_vld=0, decoder held in reset. Only cfg_start or rst leaves ERR (err clears on the honoured cfg_start).
- dec_rst_n is 0 in every state except RUN, so the decoder restarts cleanly each frame.
- rst in any state, including mid-LOAD or mid-RUN: next cycle returns to IDLE with reset values. Partially loaded tables are discarded.

Decomposition:
- Shared package holds:
  - the state enum (3-bit encoding);
  - SYM_WIDTH, SYM_COUNT, CNT_WIDTH defaults;
  - a CUM_WIDTH = CNT_WIDTH+SYM_WIDTH constant;
  - NIBBLES_PER_CNT = CNT_WIDTH/4.
- One sub-module is natural: ans_prefix_sum, a sequential accumulator with start/done handshake producing cumulative_unpacked from counts_unpacked.

Test Plan:
- Load with SYM_COUNT=16, CNT_WIDTH=8 and all counts 1 (32 nibbles 1,0,1,0...) -> cfg_rdy low after 32 transfers; 16 cycles later table_vld=1; cumulative[i]=i+1, cumulative[15]=16.
- Load counts 255 for all symbols -> cumulative[15]=4080 with no overflow; a nibble-order check (count 0x3C sent as C then 3) reads back as 0x3C.
- All counts 0 -> err=1, table_vld=0, dec_rst_n=0; a following cfg_start clears err and re-enters LOAD.
- frame_len=5 with dec_out_vld/dec_out_rdy handshakes on alternate cycles -> frame_done pulses exactly after the 5th handshake; dec_ena=0 on the next cycle; run_start then replays the frame without reload.
- frame_len=0 -> frame_done on the first RUN cycle; cfg_start together with run_start in IDLE -> LOAD taken.
- rst asserted after 10 nibbles of LOAD -> IDLE, cfg_rdy=0, counts zeroed; cfg_vld held high leaves no stray acceptance.
